// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences an external serializer and muxes
// start, data, parity and stop bits onto TX_OUT (one bit per CLK cycle).
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_load,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  frame_err,
  output logic [2:0]            fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int CW = $clog2(DATA_WIDTH + 2);

  state_t          state;
  logic [CW-1:0]   tmo_cnt;
  logic            data_par;
  logic            par_en_q;
  logic            par_typ_q;
  logic            accept;

  // Handshake: a frame is taken whenever DATA_VALID is high in IDLE or STOP;
  // there is no back-pressure signal, ser_load is the one-cycle accept strobe.
  assign accept    = DATA_VALID && !RST && (state == IDLE || state == STOP);
  assign ser_load  = accept;
  assign ser_en    = (state == START) || (state == DATA && !ser_done);
  assign Busy      = (state != IDLE);
  assign fsm_state = state;

  always_comb begin
    TX_OUT = 1'b1;
    case (state)
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = ser_data;
      PARITY:  TX_OUT = data_par ^ par_typ_q;
      default: TX_OUT = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      data_par  <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      frame_err <= 1'b0;
    end else if (accept) begin
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      data_par  <= ^P_DATA;
      frame_err <= 1'b0;
      state     <= START;
    end else begin
      case (state)
        IDLE:  state <= IDLE;
        START: begin
          tmo_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (ser_done) begin
            state <= par_en_q ? PARITY : STOP;
          end else if (tmo_cnt == CW'(DATA_WIDTH)) begin
            // Serializer never signalled its last bit: close the frame anyway.
            frame_err <= 1'b1;
            state     <= STOP;
          end
        end
        PARITY:  state <= STOP;
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: serializer model, table vectors, directed corner
// sequences and random frames checked against a frame-level line model.
module tb_uart_tx_ctrl;

  localparam int W  = 8;
  localparam int IW = $clog2(W);

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         ser_data;
  logic         ser_done;
  logic         ser_load;
  logic         ser_en;
  logic         TX_OUT;
  logic         Busy;
  logic         frame_err;
  logic [2:0]   fsm_state;

  int n_checks = 0;
  int n_err    = 0;
  logic exp_q[$];

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data),
    .ser_done(ser_done), .ser_load(ser_load), .ser_en(ser_en),
    .TX_OUT(TX_OUT), .Busy(Busy), .frame_err(frame_err),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // Serializer model: load captures the byte, each enable presents the next
  // bit (MSB first) in the following cycle; done while the last bit is shown.
  logic [W-1:0] sreg = '0;
  int           scnt = 0;
  logic         no_done = 1'b0;

  always @(posedge CLK) begin
    if (ser_load) begin
      sreg <= P_DATA;
      scnt <= 0;
    end else if (ser_en) begin
      scnt <= scnt + 1;
    end
  end

  assign ser_data = (scnt >= 1 && scnt <= W) ? sreg[IW'(W - scnt)] : 1'b0;
  assign ser_done = !no_done && (scnt == W);

  // driver helpers
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line model: start 0, data MSB first, optional parity, stop 1.
  task automatic model_frame(input logic [W-1:0] d, input logic pe, input logic pt);
    int   ones;
    logic p;
    ones = $countones(d);
    p    = ((ones % 2) == 1) ^ pt;
    exp_q.push_back(1'b0);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back(p);
    exp_q.push_back(1'b1);
  endtask

  task automatic push_bits(input logic [15:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) exp_q.push_back(bits[i]);
  endtask

  // One frame from IDLE; exp_q holds exactly the frame's line bits.
  task automatic run_frame(input logic [W-1:0] d, input logic pe, input logic pt, input string name);
    int   len;
    int   en_cnt;
    logic e;
    len    = exp_q.size();
    en_cnt = 0;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    @(negedge CLK);
    check({name, " accept load"}, ser_load, 1);
    check({name, " accept busy"}, Busy, 0);
    tick();
    P_DATA = W'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    for (int k = 0; k < len; k++) begin
      DATA_VALID = (k < len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge CLK);
      e = exp_q.pop_front();
      check({name, " tx"}, TX_OUT, e);
      check({name, " busy"}, Busy, 1);
      check({name, " no reload"}, ser_load, 0);
      if (k == 0) check({name, " err cleared"}, frame_err, 0);
      en_cnt += int'(ser_en);
      tick();
    end
    DATA_VALID = 1'b0;
    @(negedge CLK);
    check({name, " idle busy"}, Busy, 0);
    check({name, " idle tx"}, TX_OUT, 1);
    check({name, " ser_en cycles"}, en_cnt, W);
    tick();
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         pe;
    logic         pt;
    logic [15:0]  bits;
    int           len;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 16'(10'b0101001011), 10};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 16'(11'b00000011111), 11};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 16'(11'b00000011101), 11};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 16'(10'b0111111111), 10};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 16'(11'b00000000011), 11};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 16'(11'b00000000001), 11};

    RST = 1'b1; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check("reset tx", TX_OUT, 1);
      check("reset busy", Busy, 0);
      check("reset ser_en", ser_en, 0);
      check("reset ser_load", ser_load, 0);
      check("reset frame_err", frame_err, 0);
      tick();
    end

    // table vectors
    for (int i = 0; i < 6; i++) begin
      push_bits(vecs[i].bits, vecs[i].len);
      run_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, $sformatf("vec%0d", i));
    end

    // back-to-back frames with DATA_VALID held high
    begin
      int busy_cnt;
      int load_cnt;
      logic e;
      busy_cnt = 0; load_cnt = 0;
      model_frame(8'h55, 1'b0, 1'b0);
      model_frame(8'hC3, 1'b0, 1'b0);
      PAR_EN = 1'b0; PAR_TYP = 1'b0;
      for (int c = 0; c < 22; c++) begin
        DATA_VALID = (c < 20);
        P_DATA     = (c == 0) ? 8'h55 : 8'hC3;
        @(negedge CLK);
        busy_cnt += int'(Busy);
        load_cnt += int'(ser_load);
        if (c >= 1 && c <= 20) begin
          e = exp_q.pop_front();
          check("b2b tx", TX_OUT, e);
        end
        tick();
      end
      check("b2b busy cycles", busy_cnt, 20);
      check("b2b load pulses", load_cnt, 2);
    end

    // serializer never finishes: timeout after 9 DATA cycles, parity skipped
    no_done = 1'b1;
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    for (int c = 0; c < 13; c++) begin
      DATA_VALID = (c == 0);
      @(negedge CLK);
      if (c == 10) begin
        check("tmo err not yet", frame_err, 0);
        check("tmo busy in data", Busy, 1);
      end
      if (c == 11) begin
        check("tmo err set", frame_err, 1);
        check("tmo stop bit", TX_OUT, 1);
        check("tmo busy stop", Busy, 1);
      end
      if (c == 12) begin
        check("tmo idle busy", Busy, 0);
        check("tmo err sticky", frame_err, 1);
      end
      tick();
    end
    no_done = 1'b0;
    model_frame(8'h96, 1'b1, 1'b1);
    run_frame(8'h96, 1'b1, 1'b1, "after tmo");

    // reset in the 4th data-bit cycle
    P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    repeat (4) tick();
    RST = 1'b1;
    @(negedge CLK);
    check("midrst bit4", TX_OUT, 0);
    check("midrst busy before", Busy, 1);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    check("midrst tx", TX_OUT, 1);
    check("midrst busy", Busy, 0);
    tick();
    model_frame(8'h3A, 1'b1, 1'b0);
    run_frame(8'h3A, 1'b1, 1'b0, "after rst");

    // random frames against the line model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] d;
      logic pe;
      logic pt;
      d  = W'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      model_frame(d, pe, pt);
      run_frame(d, pe, pt, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame controller for the UART transmit path: accepts a parallel byte, sequences the external serializer, and muxes start, data, parity and stop bits onto the serial line. It owns the frame state machine, the parity calculation and the serial output select; the serializer only shifts data bits. CLK is the bit clock, so one bit is sent per CLK cycle.

## Interface
- DATA_WIDTH, 8, payload width; the serializer is built with the same width.
- CLK  input  1  bit clock; all state changes on rising edge.
- RST  input  1  reset, synchronous, active-high; sampled on the rising edge of CLK.
- P_DATA  input  DATA_WIDTH  byte to send; sampled when a frame is accepted.
- DATA_VALID  input  1  request; a frame is accepted when this is high in IDLE or STOP.
- PAR_EN  input  1  1 = append parity bit; latched at accept.
- PAR_TYP  input  1  0 = even, 1 = odd; latched at accept.
- ser_data  input  1  current data bit from the serializer.
- ser_done  input  1  serializer has presented its last bit.
- ser_load  output  1  combinational; high in the accept cycle; serializer loads P_DATA.
- ser_en  output  1  combinational shift enable to the serializer.
- TX_OUT  output  1  serial line; idle level 1.
- Busy  output  1  high whenever state is not IDLE.
- frame_err  output  1  sticky; set on serializer timeout; cleared at next accept or by reset.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Reset (RST=1 at an edge): state=IDLE, timeout counter=0, parity register=0, mode latches=0, frame_err=0.
- Outputs after reset: TX_OUT=1, Busy=0, ser_en=0, ser_load=0.
- Accept: DATA_VALID=1 in IDLE or STOP. On accept, ser_load=1 for that cycle. At the following edge: latch PAR_EN and PAR_TYP, compute par = ^P_DATA ^ PAR_TYP, clear frame_err, go to START.
- DATA_VALID is ignored in START, DATA and PARITY. There is no queueing.
- TX_OUT by state: IDLE=1, START=0, DATA=ser_data, PARITY=par, STOP=1.
- ser_en: 1 in START; in DATA it equals !ser_done; 0 in all other states.
- Serializer contract: each ser_en-high cycle causes the next bit to appear on ser_data in the following cycle. ser_done is high while the final bit is presented.
- START goes to DATA after 1 cycle.
- DATA: leave when ser_done=1, going to PARITY if the latched PAR_EN=1, else to STOP.
- DATA timeout: a counter increments every cycle spent in DATA. If it reaches DATA_WIDTH+1 without ser_done, set frame_err=1 and go to STOP; the stop bit is still sent. The counter clears on entering DATA.
- PARITY goes to STOP after 1 cycle.
- STOP goes to START on accept (back-to-back frames, no idle bit). Otherwise it goes to IDLE.
- Reset mid-frame: state forced to IDLE at that edge. TX_OUT=1 immediately after; the partial frame is abandoned.

## Timing
- Accept at cycle 0. START (TX_OUT=0) in cycle 1. Data bits in cycles 2..DATA_WIDTH+1.
- With parity: parity bit in cycle DATA_WIDTH+2, stop bit in cycle DATA_WIDTH+3.
- Without parity: stop bit in cycle DATA_WIDTH+2.
- Busy covers exactly the START through STOP cycles. Frame length is 10 bits (no parity) or 11 bits (parity) for DATA_WIDTH=8.
- With a compliant serializer, ser_en is high for exactly DATA_WIDTH cycles per frame: the START cycle plus DATA_WIDTH-1 DATA cycles.
- Back-to-back: accepting in the STOP cycle puts the next START in the very next cycle. Busy does not drop between the two frames.
- Parity arithmetic: even gives an even count of 1s across data plus parity; odd gives an odd count.

## Test plan
- Reset held 3 cycles, then released with DATA_VALID=0 -> TX_OUT=1, Busy=0, ser_en=0 and frame_err=0 for 5 cycles.
- P_DATA=0xA5, PAR_EN=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, taking the data bits in the order the serializer model presents them MSB-first. Busy is high for exactly 10 cycles. ser_en is high for 8 cycles.
- P_DATA=0x07, PAR_EN=1, PAR_TYP=0 -> parity bit=1. Repeat with PAR_TYP=1 -> parity bit=0. Each frame is 11 cycles.
- DATA_VALID held high with 0x55 then 0xC3 -> second START immediately follows first STOP. Busy stays high for 20 cycles. ser_load pulses exactly twice.
- Serializer model never asserts ser_done -> frame_err=1 after 9 DATA cycles, then stop bit 1, then IDLE. The next accepted frame clears frame_err.
- RST asserted in the 4th data-bit cycle -> at the next edge TX_OUT=1, Busy=0, state IDLE. A frame requested afterwards is transmitted correctly.
